mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory port between the IF stage (fetch) and the
//  MEM stage (load/store) of the 5-stage MIPS pipeline. Sits between the processor stages and the

---
 rtl/mem_port_arbiter_if.sv | 62 ++++++
 rtl/mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Brief    : Bundles the fetch, data and memory-side signals of the unified
//             memory port arbiter. The slave modport is the arbiter's view;
//             the master modport is the view of the stages plus memory model.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // processor control
    logic              start;
    // fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    // data side
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    // memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    // hazard / status
    logic              stall_if;
    logic              stall_mem;
    logic              grant_dm;

    // arbiter view
    modport slave (
        input  start,
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output stall_if, stall_mem, grant_dm
    );

    // pipeline stages and memory model view
    modport master (
        output start,
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  stall_if, stall_mem, grant_dm
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one unified instruction/data memory port between the
//             IF stage (fetch) and the MEM stage (load/store). Sequences one
//             access at a time through a multi-cycle memory, returns data
//             with a one-cycle ack and drives per-stage stall signals.
//             Data requests win over fetch requests.
//  Options  : ARB_STARVE_GUARD_EN - when defined, fetch is forced through
//             after STARVE_MAX consecutive data grants made while fetch waits.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  wire logic         clock,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // With a single-cycle memory the WAIT state is never entered.
    localparam bit c_SINGLE = (MEM_LAT == 1);
    // WAIT lasts MEM_LAT-1 cycles: the counter runs 0 .. MEM_LAT-2.
    localparam int c_WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST =
        c_WAIT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;

    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_grant_dm;

    logic                r_if_ack;
    logic                r_dm_ack;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;

    logic                w_any_req;
    logic                w_pick_dm;
    logic                w_grant;
    logic                w_mem_last;

`ifdef ARB_STARVE_GUARD_EN
    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_MAX);

    logic [c_STARVE_W-1:0] r_starve_cnt;
`else
    // The guard limit has no meaning without the starvation guard.
    logic w_unused_starve_max;
    assign w_unused_starve_max = (STARVE_MAX > 0);
`endif

    // ------------------------------------------------------------------
    // Arbitration decision: data wins unless the starvation guard trips
    // ------------------------------------------------------------------
    always_comb begin
        w_any_req = bus.if_req | bus.dm_req;
        w_pick_dm = bus.dm_req;
`ifdef ARB_STARVE_GUARD_EN
        if (bus.if_req && (r_starve_cnt == c_STARVE_LIM)) begin
            w_pick_dm = 1'b0;
        end
`endif
    end

    // A grant happens only from READY while the processor is running.
    assign w_grant = (r_state == S_READY) && bus.start && w_any_req;

    // Last cycle of the memory access: read data is sampled at its end.
    assign w_mem_last = ((r_state == S_ISSUE) && c_SINGLE) ||
                        ((r_state == S_WAIT) && (r_wait_cnt == c_WAIT_LAST));

    // ------------------------------------------------------------------
    // Main sequencer: IDLE -> READY -> ISSUE -> (WAIT) -> DONE -> READY
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_READY;
                    end
                end
                S_READY: begin
                    if (!bus.start) begin
                        r_state <= S_IDLE;
                    end else if (w_any_req) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= c_SINGLE ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // start dropping mid-access lets the access finish,
                    // then parks the arbiter in IDLE
                    r_state <= bus.start ? S_READY : S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory-side request registers, loaded with the winner on a grant
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_grant_dm  <= 1'b0;
        end else begin
            // the strobe is high only during the ISSUE cycle
            r_mem_en <= w_grant;
            if (w_grant) begin
                r_grant_dm <= w_pick_dm;
                if (w_pick_dm) begin
                    r_mem_addr  <= bus.dm_addr;
                    r_mem_wdata <= bus.dm_wdata;
                    r_mem_we    <= bus.dm_we;
                end else begin
                    // fetch never writes; keep write data untouched
                    r_mem_addr <= bus.if_addr;
                    r_mem_we   <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response path: capture read data and raise the winner's ack
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            if (w_mem_last) begin
                if (r_grant_dm) begin
                    r_dm_ack <= 1'b1;
                    // a store leaves the previous load data in place
                    if (!r_mem_we) begin
                        r_dm_rdata <= bus.mem_rdata;
                    end
                end else begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= bus.mem_rdata;
                end
            end
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    // ------------------------------------------------------------------
    // Starvation counter: data grants made while fetch is waiting
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            if (w_pick_dm && bus.if_req) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.grant_dm  = r_grant_dm;
    assign bus.if_ack    = r_if_ack;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.dm_rdata  = r_dm_rdata;

    // Stalls track the live request against this cycle's ack.
    assign bus.stall_if  = bus.if_req & ~r_if_ack;
    assign bus.stall_mem = bus.dm_req & ~r_dm_ack;

endmodule
`default_nettype wire
